// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX hazard/forwarding logic.
//   sb_entry_t : one scoreboard slot {valid, rd, is_load} for an in-flight instruction.
//   FWD_RF     : forwarding-select value meaning "take the operand from the register file".
//   REG_ZERO   : the hard-wired zero register address.
// rd is stored at a fixed width of SB_RD_W bits so the struct does not depend on the
// register address width chosen by the instantiating module; narrower addresses are
// zero-extended. Register address widths above SB_RD_W are not supported.
package dlx_pkg;

  localparam int unsigned SB_RD_W = 8;

  localparam int unsigned FWD_RF = 0;

  localparam logic [SB_RD_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/dlx_fwd_match.sv
// Combinational nearest-producer search for one source register.
//   entries   : scoreboard, index 0 = EX, DEPTH-1 = oldest tracked stage
//   src       : zero-extended source register address
//   hit       : some entry with index >= MIN_K writes src
//   k         : index of the nearest (smallest-index) such entry
//   available : that entry's result can be forwarded now (not a load still in flight)
// Only the nearest producer is reported; older writers of the same register are shadowed.
module dlx_fwd_match
  import dlx_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MIN_K    = 0,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [SB_RD_W-1:0]    src,
  output logic                  hit,
  output logic [SEL_W-1:0]      k,
  output logic                  available
);

  // Walk from oldest to youngest so the last match written is the nearest one.
  always_comb begin
    hit       = 1'b0;
    k         = '0;
    available = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= int'(MIN_K); i--) begin
      if (entries[i].valid && (entries[i].rd == src)) begin
        hit       = 1'b1;
        k         = SEL_W'(i);
        available = !entries[i].is_load || (i >= int'(LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// Hazard and forwarding controller for the DLX pipeline, placed beside the ID stage.
// Tracks the destination registers of the DEPTH stages after ID and produces:
//   stall       : hold PC and IF/ID, inject a bubble into EX (load-use / branch hazards)
//   flush       : squash IF/ID on a taken branch or jump (ex_redirect)
//   fwd_a_sel,
//   fwd_b_sel   : registered EX operand selects, 0 = register file, k = stage k-1 result
//   id_fwd_sel  : combinational ID branch-compare select for rs1, same encoding, k >= 1 only
//   stall_cnt   : saturating count of stall cycles
// Inputs are the decoded ID fields (id_*) and the EX redirect. clk/reset are the system
// clock and a synchronous active-high reset.
module dlx_hazard_ctrl
  import dlx_pkg::*;
#(
  parameter  int unsigned REG_AW   = 5,
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned LOAD_LAT = 1,
  parameter  int unsigned CNT_W    = 32,
  localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              id_branch,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [SEL_W-1:0]  id_fwd_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [SEL_W-1:0]      fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]      fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SB_RD_W-1:0] rs1_ext, rs2_ext, rd_ext;
  assign rs1_ext = SB_RD_W'(id_rs1);
  assign rs2_ext = SB_RD_W'(id_rs2);
  assign rd_ext  = SB_RD_W'(id_rd);

  logic             hit_a, hit_b, hit_br;
  logic [SEL_W-1:0] k_a, k_b, k_br;
  logic             av_a, av_b, av_br;

  dlx_fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .MIN_K    (0),
    .SEL_W    (SEL_W)
  ) u_match_rs1 (
    .entries   (sb_q),
    .src       (rs1_ext),
    .hit       (hit_a),
    .k         (k_a),
    .available (av_a)
  );

  dlx_fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .MIN_K    (0),
    .SEL_W    (SEL_W)
  ) u_match_rs2 (
    .entries   (sb_q),
    .src       (rs2_ext),
    .hit       (hit_b),
    .k         (k_b),
    .available (av_b)
  );

  // The branch compare happens in ID, so the EX-stage result (k = 0) is never usable.
  dlx_fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .MIN_K    (1),
    .SEL_W    (SEL_W)
  ) u_match_br (
    .entries   (sb_q),
    .src       (rs1_ext),
    .hit       (hit_br),
    .k         (k_br),
    .available (av_br)
  );

  logic load_use, br_hazard, issue;

  always_comb begin
    load_use  = (id_use_rs1 && hit_a && !av_a) || (id_use_rs2 && hit_b && !av_b);
    br_hazard = id_branch && hit_a && ((k_a == '0) || !av_a);
    flush     = ex_redirect;
    // Flush wins over stall: the ID instruction is squashed anyway.
    stall     = id_valid && !ex_redirect && (load_use || br_hazard);
    issue     = id_valid && !stall && !flush;
  end

  always_comb begin
    id_fwd_sel = SEL_W'(FWD_RF);
    if (id_valid && id_use_rs1 && hit_br && av_br) begin
      id_fwd_sel = k_br + SEL_W'(1);
    end
  end

  always_comb begin
    sb_d = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (issue) begin
      sb_d[0].valid   = id_reg_wr && (rd_ext != REG_ZERO);
      sb_d[0].rd      = rd_ext;
      sb_d[0].is_load = id_is_load;
    end

    // Selects follow the instruction into EX; a bubble always reads the register file.
    fwd_a_d = SEL_W'(FWD_RF);
    fwd_b_d = SEL_W'(FWD_RF);
    if (issue && id_use_rs1 && hit_a && av_a) begin
      fwd_a_d = k_a + SEL_W'(1);
    end
    if (issue && id_use_rs2 && hit_b && av_b) begin
      fwd_b_d = k_b + SEL_W'(1);
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q    <= '0;
      fwd_a_q <= SEL_W'(FWD_RF);
      fwd_b_q <= SEL_W'(FWD_RF);
      cnt_q   <= '0;
    end else begin
      sb_q    <= sb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Bench for dlx_hazard_ctrl (DEPTH=3, LOAD_LAT=1, CNT_W=2 so saturation is reachable).
// Each cycle drives one ID instruction, checks the combinational outputs before the edge,
// queues the expected registered selects, and compares them once the instruction is in EX.
module tb_dlx_hazard_ctrl;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned SEL_W    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_reg_wr, id_is_load, id_branch;
  logic              ex_redirect;
  logic              stall, flush;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel, id_fwd_sel;
  logic [CNT_W-1:0]  stall_cnt;

  dlx_hazard_ctrl #(
    .REG_AW   (REG_AW),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_wr   (id_reg_wr),
    .id_is_load  (id_is_load),
    .id_branch   (id_branch),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .id_fwd_sel  (id_fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
  } instr_t;

  typedef struct packed {
    logic [SEL_W-1:0] fa;
    logic [SEL_W-1:0] fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
    return '{valid: 1'b1, rs1: rs1, rs2: rs2, use1: 1'b1, use2: 1'b1, rd: rd,
             wr: 1'b1, ld: 1'b0, br: 1'b0};
  endfunction

  function automatic instr_t alui(input logic [4:0] rd, input logic [4:0] rs1);
    return '{valid: 1'b1, rs1: rs1, rs2: 5'd0, use1: 1'b1, use2: 1'b0, rd: rd,
             wr: 1'b1, ld: 1'b0, br: 1'b0};
  endfunction

  function automatic instr_t load(input logic [4:0] rd, input logic [4:0] rs1);
    return '{valid: 1'b1, rs1: rs1, rs2: 5'd0, use1: 1'b1, use2: 1'b0, rd: rd,
             wr: 1'b1, ld: 1'b1, br: 1'b0};
  endfunction

  function automatic instr_t beqz(input logic [4:0] rs1);
    return '{valid: 1'b1, rs1: rs1, rs2: 5'd0, use1: 1'b1, use2: 1'b0, rd: 5'd0,
             wr: 1'b0, ld: 1'b0, br: 1'b1};
  endfunction

  function automatic instr_t nop();
    return '0;
  endfunction

  task automatic apply(input instr_t i, input logic redir);
    id_valid    = i.valid;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_use_rs1  = i.use1;
    id_use_rs2  = i.use2;
    id_rd       = i.rd;
    id_reg_wr   = i.wr;
    id_is_load  = i.ld;
    id_branch   = i.br;
    ex_redirect = redir;
  endtask

  // e_idsel < 0 skips the id_fwd_sel comparison for that cycle.
  task automatic cyc(input string tag, input instr_t i, input logic redir, input logic e_stall,
                     input int e_idsel, input logic [SEL_W-1:0] e_fa,
                     input logic [SEL_W-1:0] e_fb);
    exp_t e;
    apply(i, redir);
    @(negedge clk);
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(redir));
    if (e_idsel >= 0) check({tag, ".id_fwd_sel"}, 32'(id_fwd_sel), 32'(e_idsel));
    exp_q.push_back('{fa: e_fa, fb: e_fb});
    if (e_stall && exp_cnt < 3) exp_cnt++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".fwd_a_sel"}, 32'(fwd_a_sel), 32'(e.fa));
    check({tag, ".fwd_b_sel"}, 32'(fwd_b_sel), 32'(e.fb));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
  endtask

  task automatic drain();
    for (int n = 0; n < 3; n++) cyc("drain", nop(), 1'b0, 1'b0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    reset = 1'b1;
    apply(nop(), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
    check("rst.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.flush", 32'(flush), 32'd0);
    check("rst.id_fwd_sel", 32'(id_fwd_sel), 32'd0);
    reset = 1'b0;

    // Back-to-back ALU dependencies, including an rs2 forward and a two-stage forward.
    cyc("alu.add",  alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("alu.sub",  alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b0, 0, 2'd1, 2'd0);
    cyc("alu.both", alu(5'd11, 5'd3, 5'd4), 1'b0, 1'b0, -1, 2'd2, 2'd1);
    drain();

    // Load-use: one stall, then forward from stage 1.
    cyc("ld.lw",    load(5'd6, 5'd1), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("ld.stall", alu(5'd7, 5'd6, 5'd1), 1'b0, 1'b1, 0, 2'd0, 2'd0);
    cyc("ld.use",   alu(5'd7, 5'd6, 5'd1), 1'b0, 1'b0, -1, 2'd2, 2'd0);
    drain();

    // Writes to r0 are never tracked.
    cyc("r0.addi", alui(5'd0, 5'd1), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("r0.add",  alu(5'd2, 5'd0, 5'd0), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    drain();

    // Nearest producer shadows the older one.
    cyc("near.p1", alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("near.p2", alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("near.c",  alu(5'd8, 5'd3, 5'd9), 1'b0, 1'b0, -1, 2'd1, 2'd0);
    drain();

    // Redirect during a load-use hazard: flush wins, bubble enters EX.
    cyc("fl.lw",  load(5'd6, 5'd1), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("fl.use", alu(5'd7, 5'd6, 5'd1), 1'b1, 1'b0, 0, 2'd0, 2'd0);
    cyc("fl.nxt", nop(), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    drain();

    // Branch on an ALU result: one stall, then ID compare forwards from stage 1.
    cyc("br.add",   alu(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    cyc("br.stall", beqz(5'd1), 1'b0, 1'b1, 0, 2'd0, 2'd0);
    cyc("br.go",    beqz(5'd1), 1'b0, 1'b0, 2, 2'd2, 2'd0);
    // Further stalls drive the 2-bit counter into saturation.
    for (int n = 0; n < 2; n++) begin
      cyc("sat.lw",    load(5'd5, 5'd7), 1'b0, 1'b0, 0, 2'd0, 2'd0);
      cyc("sat.stall", beqz(5'd5), 1'b0, 1'b1, 0, 2'd0, 2'd0);
      cyc("sat.go",    beqz(5'd5), 1'b0, 1'b0, 2, 2'd2, 2'd0);
    end
    drain();

    // Reset mid-sequence forgets the in-flight producer and clears the counter.
    cyc("mr.add", alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, 2'd0, 2'd0);
    apply(alu(5'd4, 5'd3, 5'd5), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    check("mr.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
    check("mr.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
    check("mr.stall_cnt", 32'(stall_cnt), 32'd0);
    cyc("mr.sub", alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b0, 0, 2'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dlx_hazard_ctrl.md
Name: dlx_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the DLX pipeline. Sits beside the ID stage and consumes the decoded register fields and control bits from the control decoder.
- Keeps a shadow scoreboard of the in-flight destination registers for every stage after ID.
- Produces the ID stall, the branch/jump flush, and registered operand-forwarding selects for the EX stage.
- Generalises the fixed EX/MEM and MEM/WB forwarding bits into a configurable depth, with load-latency-aware stalling and a stall performance counter.

Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 3, number of tracked stages after ID (index 0 = EX, DEPTH-1 = last stage before writeback completes); legal range 2..6.
- LOAD_LAT, 1, stages a load must pass beyond EX before its data is forwardable; legal range 1..DEPTH-1.
- CNT_W, 32, width of the stall performance counter.
- SEL_W, $clog2(DEPTH+1), width of the forwarding selects (derived, not overridable).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (0 = bubble or NOP).
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_use_rs1, id_use_rs2  in  1  the instruction reads that source.
- id_rd  in  REG_AW  destination register, already muxed by regDst or link.
- id_reg_wr  in  1  the instruction writes id_rd.
- id_is_load  in  1  load instruction.
- id_branch  in  1  beqz/bnez/jr/jalr; rs1 is needed in ID.
- ex_redirect  in  1  branch or jump resolved taken (PC redirect this cycle).
- stall  out  1  hold PC and the IF/ID register; inject a bubble into EX.
- flush  out  1  squash the IF/ID contents.
- fwd_a_sel, fwd_b_sel  out  SEL_W  registered EX operand mux select: 0 = register file, k = stage k-1 result.
- id_fwd_sel  out  SEL_W  combinational ID branch-compare select for rs1; same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard holds DEPTH entries {valid, rd, is_load}. Each clock, entry[k] <= entry[k-1] for k≥1.
- entry[0] <= the ID instruction when id_valid && !stall && !flush; otherwise entry[0] <= bubble (valid=0).
- Stored valid = id_valid & id_reg_wr & (id_rd != 0). An rd of 0 never matches anything.
- Match(src, k): entry[k].valid && entry[k].rd == src.
- Available(k): !entry[k].is_load || k ≥ LOAD_LAT.
- Nearest-match rule: for each used source, pick the smallest k with Match. Only the nearest match counts; older matches are shadowed.
- Stall on load-use: a used source's nearest match is not Available.
- Stall on branch: id_branch and rs1's nearest match is at k=0 (ALU result not yet produced), or that match is not Available.
- stall is combinational and is gated by id_valid.
- Forwarding selects:
  - fwd_a_sel / fwd_b_sel = k+1 of the nearest Available match, else 0. Computed in ID and registered at the same edge as entry[0].
  - Forced to 0 when entry[0] is loaded with a bubble.
  - Latency: 1 cycle, aligned with the instruction in EX.
  - id_fwd_sel uses the same rule for rs1 with k ≥ 1 only, and is combinational.
- flush = ex_redirect, combinational.
- Flush and stall together: flush wins. stall is forced to 0, a bubble enters EX, and the squashed ID instruction is not recorded.
- Stall counter: stall_cnt increments on every cycle with stall=1 and saturates at all-ones (no wrap).
- Reset: all entries invalid, fwd_a_sel = fwd_b_sel = 0, stall_cnt = 0. stall, flush and id_fwd_sel are therefore 0 while reset is held and ex_redirect=0.
- Reset asserted mid-operation clears the scoreboard at that edge. Any in-flight producers are forgotten.
- A stall never lasts more than LOAD_LAT+1 consecutive cycles for a single instruction, because bubbles advance the producer.

Decomposition:
- Shared package dlx_pkg:
  - sb_entry_t struct {valid, rd, is_load}.
  - FWD_RF = 0 select constant.
  - REG_ZERO constant.
- Sub-module dlx_fwd_match: purely combinational priority search over the DEPTH entries for one source; returns {hit, k, available}. Instantiate it three times (rs1, rs2, branch rs1).

Test Plan:
- Back-to-back ALU dependency: add r3←r1+r2, then sub r4←r3-r5 → no stall; fwd_a_sel=1 when sub is in EX.
- Load-use with LOAD_LAT=1: lw r6, then add r7←r6+r1 → stall=1 for exactly 1 cycle, stall_cnt=1; then fwd_a_sel=2.
- Destination r0: addi r0←r1+5, then add r2←r0+r0 → no stall; both selects 0.
- Nearest match: add r3; add r3; add r8←r3 → fwd_a_sel=1, not 2.
- Flush during stall: load-use stall with ex_redirect=1 in the same cycle → stall=0, flush=1, entry[0] bubble; next-cycle fwd selects 0.
- Branch hazard plus counter saturation (CNT_W=2): add r1, then beqz r1 → 1 stall, then id_fwd_sel=2. Repeat stalls → stall_cnt holds at 3. Mid-sequence reset → stall_cnt=0 and selects 0 after the edge.
